// File: rtl/wb_commit_unit.sv
// wb_commit_unit
// Writeback/commit stage. It consumes the WB bundle over a valid/ready handshake.
// It writes the integer register file, where x0 always reads as zero.
// It serves two decode read ports and bypasses the write accepted in the same cycle.
// It queues every accepted instruction for the trace/difftest consumer.
// wb_ready goes low when the commit queue is full, which applies backpressure to the pipeline.

module wb_commit_unit #(
    parameter int XLEN     = 64,
    parameter int PC_W     = 64,
    parameter int INST_W   = 32,
    parameter int CQ_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,

    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic                        wb_w_ena,
    input  logic [4:0]                  wb_w_addr,
    input  logic [XLEN-1:0]             wb_w_data,
    input  logic [PC_W-1:0]             wb_pc,
    input  logic [INST_W-1:0]           wb_instr,

    input  logic [4:0]                  rs1_addr,
    output logic [XLEN-1:0]             rs1_data,
    input  logic [4:0]                  rs2_addr,
    output logic [XLEN-1:0]             rs2_data,

    output logic                        cm_valid,
    input  logic                        cm_ready,
    output logic [PC_W-1:0]             cm_pc,
    output logic [INST_W-1:0]           cm_instr,
    output logic                        cm_w_ena,
    output logic [4:0]                  cm_w_addr,
    output logic [XLEN-1:0]             cm_w_data,
    output logic [$clog2(CQ_DEPTH):0]   cq_count,
    output logic [63:0]                 retired
);

    localparam int PTR_W = $clog2(CQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CQ_DEPTH);

    // Handshake
    logic accept;
    logic pop;
    logic reg_we;
    logic ent_w_ena;

    // Architectural register file. x0 is reset with the others and never written,
    // so it stays zero. The read ports also mask address 0 explicitly.
    logic [XLEN-1:0]   regs_q [32];

    // Commit queue storage
    logic [PC_W-1:0]   cq_pc_q    [CQ_DEPTH];
    logic [INST_W-1:0] cq_instr_q [CQ_DEPTH];
    logic              cq_wena_q  [CQ_DEPTH];
    logic [4:0]        cq_waddr_q [CQ_DEPTH];
    logic [XLEN-1:0]   cq_wdata_q [CQ_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [63:0]       retired_q, retired_d;

    assign wb_ready  = (count_q != FULL_CNT);
    assign accept    = wb_valid & wb_ready;
    assign cm_valid  = (count_q != '0);
    assign pop       = cm_valid & cm_ready;
    assign ent_w_ena = wb_w_ena & (wb_w_addr != 5'd0);
    assign reg_we    = accept & ent_w_ena;

    // Read ports. The write being accepted this cycle bypasses the register array,
    // so decode sees the value without a one-cycle bubble.
    assign rs1_data = (rs1_addr == 5'd0)                          ? '0 :
                      (accept & wb_w_ena & (wb_w_addr == rs1_addr)) ? wb_w_data :
                      regs_q[rs1_addr];

    assign rs2_data = (rs2_addr == 5'd0)                          ? '0 :
                      (accept & wb_w_ena & (wb_w_addr == rs2_addr)) ? wb_w_data :
                      regs_q[rs2_addr];

    // The queue head drives the cm_* outputs directly.
    // Storage is cleared on reset, so these outputs read zero until the first push.
    assign cm_pc     = cq_pc_q[rd_ptr_q];
    assign cm_instr  = cq_instr_q[rd_ptr_q];
    assign cm_w_ena  = cq_wena_q[rd_ptr_q];
    assign cm_w_addr = cq_waddr_q[rd_ptr_q];
    assign cm_w_data = cq_wdata_q[rd_ptr_q];
    assign cq_count  = count_q;
    assign retired   = retired_q;

    // Next-state for the queue pointers, occupancy and retire counter.
    // The pointers wrap naturally because CQ_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        retired_d = retired_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            retired_d = retired_q + 64'd1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Register file write on accept; all registers are cleared on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[wb_w_addr] <= wb_w_data;
        end
    end

    // Commit queue payload. Reset discards the contents, so a stale head never
    // reappears on cm_* afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CQ_DEPTH; i++) begin
                cq_pc_q[i]    <= '0;
                cq_instr_q[i] <= '0;
                cq_wena_q[i]  <= 1'b0;
                cq_waddr_q[i] <= '0;
                cq_wdata_q[i] <= '0;
            end
        end else if (accept) begin
            cq_pc_q[wr_ptr_q]    <= wb_pc;
            cq_instr_q[wr_ptr_q] <= wb_instr;
            cq_wena_q[wr_ptr_q]  <= ent_w_ena;
            cq_waddr_q[wr_ptr_q] <= wb_w_addr;
            cq_wdata_q[wr_ptr_q] <= wb_w_data;
        end
    end

    // Queue pointers, occupancy and the retire counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            retired_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Testbench for wb_commit_unit. The reference model keeps the register file as an array
// and the commit queue as a SystemVerilog queue of entries.

module tb_wb_commit_unit;

    localparam int XLEN     = 64;
    localparam int PC_W     = 64;
    localparam int INST_W   = 32;
    localparam int CQ_DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              wb_valid;
    logic              wb_ready;
    logic              wb_w_ena;
    logic [4:0]        wb_w_addr;
    logic [XLEN-1:0]   wb_w_data;
    logic [PC_W-1:0]   wb_pc;
    logic [INST_W-1:0] wb_instr;
    logic [4:0]        rs1_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [4:0]        rs2_addr;
    logic [XLEN-1:0]   rs2_data;
    logic              cm_valid;
    logic              cm_ready;
    logic [PC_W-1:0]   cm_pc;
    logic [INST_W-1:0] cm_instr;
    logic              cm_w_ena;
    logic [4:0]        cm_w_addr;
    logic [XLEN-1:0]   cm_w_data;
    logic [2:0]        cq_count;
    logic [63:0]       retired;

    always #5 clock = ~clock;

    wb_commit_unit #(
        .XLEN(XLEN), .PC_W(PC_W), .INST_W(INST_W), .CQ_DEPTH(CQ_DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_w_ena(wb_w_ena),
        .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_pc(cm_pc), .cm_instr(cm_instr),
        .cm_w_ena(cm_w_ena), .cm_w_addr(cm_w_addr), .cm_w_data(cm_w_data),
        .cq_count(cq_count), .retired(retired)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        w_ena;
        logic [4:0]  addr;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] mregs [32];
    logic [63:0] mret;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mread(input logic [4:0] a, input logic acc);
        if (a == 5'd0) return 64'd0;
        if (acc && wb_w_ena && wb_w_addr == a) return wb_w_data;
        return mregs[a];
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        mret = 64'd0;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [63:0] pc, input logic [31:0] ins);
        wb_valid  = v;
        wb_w_ena  = we;
        wb_w_addr = wa;
        wb_w_data = wd;
        wb_pc     = pc;
        wb_instr  = ins;
    endtask

    // Check all outputs against the model, clock once, then advance the model.
    task automatic cycle();
        logic acc, pp;
        ent_t e;
        @(negedge clock);
        acc = wb_valid && (mq.size() < CQ_DEPTH);
        pp  = (mq.size() > 0) && cm_ready;
        chk("wb_ready", {63'd0, wb_ready}, {63'd0, mq.size() < CQ_DEPTH});
        chk("cq_count", {61'd0, cq_count}, 64'(mq.size()));
        chk("cm_valid", {63'd0, cm_valid}, {63'd0, mq.size() > 0});
        chk("retired",  retired, mret);
        chk("rs1_data", rs1_data, mread(rs1_addr, acc));
        chk("rs2_data", rs2_data, mread(rs2_addr, acc));
        if (mq.size() > 0) begin
            chk("cm_pc",     cm_pc, mq[0].pc);
            chk("cm_instr",  {32'd0, cm_instr}, {32'd0, mq[0].instr});
            chk("cm_w_ena",  {63'd0, cm_w_ena}, {63'd0, mq[0].w_ena});
            chk("cm_w_addr", {59'd0, cm_w_addr}, {59'd0, mq[0].addr});
            chk("cm_w_data", cm_w_data, mq[0].data);
        end
        @(posedge clock);
        #1;
        if (pp) begin
            void'(mq.pop_front());
            mret = mret + 64'd1;
        end
        if (acc) begin
            e.pc    = wb_pc;
            e.instr = wb_instr;
            e.w_ena = wb_w_ena && (wb_w_addr != 5'd0);
            e.addr  = wb_w_addr;
            e.data  = wb_w_data;
            mq.push_back(e);
            if (e.w_ena) mregs[wb_w_addr] = wb_w_data;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wb_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [63:0] base;
        logic [63:0] pre;
        reset    = 1'b1;
        cm_ready = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
        model_clear();
        @(posedge clock);
        do_reset();

        // 1: reset state, all registers read zero
        chk("rst_cm_valid", {63'd0, cm_valid}, 64'd0);
        chk("rst_wb_ready", {63'd0, wb_ready}, 64'd1);
        chk("rst_retired",  retired, 64'd0);
        chk("rst_cm_pc",    cm_pc, 64'd0);
        chk("rst_cm_data",  cm_w_data, 64'd0);
        chk("rst_cm_instr", {32'd0, cm_instr}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            cycle();
        end

        // 2: bypass on accept, then value from the register array
        cm_ready = 1'b1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd6;
        drive(1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF, 64'h100, 32'h0000_0013);
        #1 chk("t2_bypass", rs1_data, 64'hDEAD_BEEF);
        cycle();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
        #1 chk("t2_regs", rs1_data, 64'hDEAD_BEEF);
        cycle();

        // 3: write to x0 is dropped and committed with w_ena=0
        rs1_addr = 5'd0;
        drive(1'b1, 1'b1, 5'd0, 64'h1234, 64'h104, 32'h0000_0093);
        #1 chk("t3_x0_bypass", rs1_data, 64'd0);
        cycle();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
        chk("t3_cm_w_ena", {63'd0, cm_w_ena}, 64'd0);
        chk("t3_x0_read", rs1_data, 64'd0);
        cycle();
        cycle();

        // 4: fill the queue, blocked 5th push, drain in order
        base     = mret;
        cm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rs1_addr = 5'(i + 1);
            drive(1'b1, 1'b1, 5'(i + 1), {$urandom, $urandom}, 64'h200 + 64'(4 * i), $urandom);
            cycle();
        end
        chk("t4_count_full", {61'd0, cq_count}, 64'd4);
        chk("t4_ready_low",  {63'd0, wb_ready}, 64'd0);
        rs1_addr = 5'd7;
        pre = mregs[7];
        drive(1'b1, 1'b1, 5'd7, 64'hBAD0_BAD0_BAD0_BAD0, 64'h300, 32'hFFFF_FFFF);
        #1 chk("t4_no_bypass_full", rs1_data, pre);
        cycle();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
        chk("t4_reg_unchanged", rs1_data, pre);
        cm_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("t4_retired", retired, base + 64'd4);
        chk("t4_empty", {61'd0, cq_count}, 64'd0);

        // 5: streaming with consumer always ready
        base = mret;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'($urandom), 5'($urandom), {$urandom, $urandom},
                  64'h8000_0000 + 64'(4 * i), $urandom);
            rs1_addr = wb_w_addr;
            rs2_addr = 5'($urandom);
            cycle();
            chk("t5_count_le1", {63'd0, cq_count <= 3'd1}, 64'd1);
            chk("t5_cm_pc", cm_pc, 64'h8000_0000 + 64'(4 * i));
        end
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
        cycle();
        chk("t5_retired", retired, base + 64'd10);

        // 6: reset with entries queued
        cm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'(i + 3), {$urandom, $urandom}, 64'h400 + 64'(4 * i), $urandom);
            cycle();
        end
        chk("t6_count_pre", {61'd0, cq_count}, 64'd3);
        do_reset();
        rs1_addr = 5'd3;
        rs2_addr = 5'd5;
        #1;
        chk("t6_cm_valid", {63'd0, cm_valid}, 64'd0);
        chk("t6_count",    {61'd0, cq_count}, 64'd0);
        chk("t6_rs1",      rs1_data, 64'd0);
        chk("t6_rs2",      rs2_data, 64'd0);
        chk("t6_retired",  retired, 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end
            cm_ready = ($urandom_range(0, 2) != 0);
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 7)),
                  {$urandom, $urandom}, {$urandom, $urandom}, $urandom);
            rs1_addr = ($urandom_range(0, 1) == 0) ? wb_w_addr : 5'($urandom_range(0, 7));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr  : 5'($urandom_range(0, 7));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
